evt_flt_set: RTL and testbench
==============================

EVT_FLT_SET -- requirements
Module: evt_flt_set

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning number of event bits, matching the downstream read/write/clear status register width.
REQ-002 The block SHALL have parameter FLT_CNT_W, default 4, meaning the filter counter width.
REQ-003 The block SHALL have parameter FLT_LEN, default 3, meaning consecutive mismatch cycles needed to change the filtered level; legal range 0..2^FLT_CNT_W-1, with 0 treated as 1.
REQ-004 The block SHALL have parameter SYNC_EN, default 1'b1, meaning a 2-flop synchronizer per bit is present; 0 means bypass.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port list, clock and reset first:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_evt  in  DW  raw event/fault levels, possibly asynchronous.
- i_evt_en  in  DW  per-bit event enable.
- i_edge_sel  in  DW  per-bit edge select: 0 = rising, 1 = falling filtered edge.
- i_reg_data  in  DW  current status register contents fed back from the register.
- i_irq_en  in  DW  per-bit interrupt enable.
- o_lgc_wen  out  DW  per-bit logic set strobe to the status register.
- o_lgc_wdata  out  DW  per-bit logic write data.
- o_irq  out  1  level interrupt.

Function
REQ-007 The synchronized level sync[i] SHALL be i_evt[i] through two flops when SYNC_EN=1, and i_evt[i] directly when SYNC_EN=0.
REQ-008 Each bit SHALL hold a filtered level filt[i] and a counter cnt[i] (FLT_CNT_W bits), with the following per-cycle behaviour:
- if sync==filt: cnt clears to 0.
- else if cnt==FLT_LEN_EFF-1: filt toggles and cnt clears to 0.
- else: cnt increments by 1.
- cnt SHALL never wrap.
REQ-009 Any sync excursion shorter than FLT_LEN_EFF consecutive cycles SHALL leave filt unchanged and SHALL produce no strobe.
REQ-010 On the edge where filt toggles in the direction selected by i_edge_sel[i], with i_evt_en[i]=1 at that edge, o_lgc_wen[i] SHALL be registered high for exactly one cycle.
REQ-011 A toggle in the non-selected direction, or a toggle with i_evt_en[i]=0, SHALL produce no strobe and SHALL NOT be remembered.
REQ-012 o_lgc_wdata SHALL equal o_lgc_wen at all times, so the block only ever sets register bits.
REQ-013 Latency with SYNC_EN=1: if i_evt[i] is first sampled high at edge k and held, filt SHALL toggle at edge k+1+FLT_LEN_EFF and o_lgc_wen[i] SHALL be high during the cycle after that edge.
REQ-014 Latency with SYNC_EN=0: the filt toggle SHALL occur at edge k+FLT_LEN_EFF-1.
REQ-015 An i_evt_en[i] rise while filt[i] is already in the selected state SHALL NOT generate a strobe, because strobes are edge-only.
REQ-016 A change of i_edge_sel[i] SHALL take effect on the next filt toggle and SHALL NOT itself generate a strobe.
REQ-017 Bits SHALL be fully independent, and simultaneous strobes on several bits in one cycle SHALL all be issued.
REQ-018 o_irq SHALL be registered as |(i_reg_data & i_irq_en), giving 1-cycle latency; it SHALL stay high until the CPU clears the register bit or the enable is removed.
REQ-019 A register clear by the CPU in the same cycle as o_lgc_wen SHALL result in the bit being set, because the downstream register gives logic write priority; this block SHALL NOT suppress the strobe.

Reset
REQ-020 With i_rst high at an edge, the synchronizer flops, filt, cnt, o_lgc_wen, o_lgc_wdata and o_irq SHALL all be 0 after that edge.
REQ-021 Reset asserted mid-filter SHALL discard the partial count.
REQ-022 An input held high through reset release SHALL be treated as a new rising edge and SHALL strobe per REQ-013.

Structure
REQ-023 No shared typedefs are required; FLT_LEN_EFF SHALL be a local constant, and any project-wide default FLT_LEN SHALL live in the shared cbb package.
REQ-024 The per-bit synchronizer, filter and edge logic SHALL be one sub-module, evt_flt_bit, generated DW times; IRQ reduction SHALL stay in the top level.

Verification
REQ-025 The bench SHALL cover the following directed scenarios, with SYNC_EN=1 and FLT_LEN=3 unless stated:
- Rising edge: i_evt[0] rises before edge 10 and holds -> o_lgc_wen=8'h01 and o_lgc_wdata=8'h01 for exactly one cycle after edge 14, with no further strobe.
- Glitch: 2-cycle pulse on i_evt[3] -> o_lgc_wen stays 0; a 3-cycle pulse -> one strobe on bit 3.
- Falling edge: i_edge_sel[2]=1; i_evt[2] goes high then low (each held 5 cycles) -> a single strobe on bit 2, only after the fall.
- Masking and IRQ: i_evt_en[5]=0 during the edge -> no strobe; then i_reg_data=8'h20 and i_irq_en=8'h20 -> o_irq high 1 cycle later; clearing i_irq_en -> o_irq low 1 cycle later.
- Reset: i_rst pulsed mid-count with i_evt[1] held high -> all outputs 0 after the reset edge, then one strobe on bit 1 FLT_LEN+2 edges after release.
- Configuration corners: FLT_LEN=0 and SYNC_EN=0 -> strobe in the cycle after the first sampling edge; simultaneous edges on all 8 bits -> o_lgc_wen=8'hFF for one cycle.

Source files
------------

// File: rtl/evt_flt_set_pkg.sv
// rtl/evt_flt_set_pkg.sv - shared constants for the event filter/set block
package evt_flt_set_pkg;

    localparam int FLT_LEN_DEFAULT = 3;

    // A filter length of 0 behaves like 1: every settled change is accepted next edge.
    function automatic int flt_len_eff(input int len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/evt_flt_bit.sv
// rtl/evt_flt_bit.sv - per-bit synchronizer, glitch filter and edge strobe
module evt_flt_bit
    import evt_flt_set_pkg::*;
#(
    parameter int   FLT_CNT_W = 4,
    parameter int   FLT_LEN   = FLT_LEN_DEFAULT,
    parameter logic SYNC_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic evt,
    input  logic evt_en,
    input  logic edge_sel,
    output logic wen
);

    localparam int FLT_LEN_EFF = flt_len_eff(FLT_LEN);
    localparam logic [FLT_CNT_W-1:0] CNT_LAST = FLT_CNT_W'(FLT_LEN_EFF - 1);

    logic                 sync;
    logic                 filt;
    logic [FLT_CNT_W-1:0] cnt;
    logic                 toggle;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] meta;
            always_ff @(posedge clk) begin
                if (rst) meta <= '0;
                else     meta <= {meta[0], evt};
            end
            assign sync = meta[1];
        end else begin : g_bypass
            assign sync = evt;
        end
    endgenerate

    assign toggle = (sync != filt) && (cnt == CNT_LAST);

    // Current filt equal to edge_sel means the toggle is in the selected direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
            wen  <= 1'b0;
        end else begin
            wen <= toggle && evt_en && (filt == edge_sel);
            if (sync == filt) begin
                cnt <= '0;
            end else if (toggle) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/evt_flt_set.sv
// rtl/evt_flt_set.sv - filtered event edges to status-register set strobes plus IRQ
module evt_flt_set
    import evt_flt_set_pkg::*;
#(
    parameter int   DW        = 8,
    parameter int   FLT_CNT_W = 4,
    parameter int   FLT_LEN   = FLT_LEN_DEFAULT,
    parameter logic SYNC_EN   = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_evt,
    input  logic [DW-1:0] i_evt_en,
    input  logic [DW-1:0] i_edge_sel,
    input  logic [DW-1:0] i_reg_data,
    input  logic [DW-1:0] i_irq_en,
    output logic [DW-1:0] o_lgc_wen,
    output logic [DW-1:0] o_lgc_wdata,
    output logic          o_irq
);

    logic [DW-1:0] wen;

    for (genvar i = 0; i < DW; i++) begin : g_bit
        evt_flt_bit #(
            .FLT_CNT_W (FLT_CNT_W),
            .FLT_LEN   (FLT_LEN),
            .SYNC_EN   (SYNC_EN)
        ) u_bit (
            .clk      (i_clk),
            .rst      (i_rst),
            .evt      (i_evt[i]),
            .evt_en   (i_evt_en[i]),
            .edge_sel (i_edge_sel[i]),
            .wen      (wen[i])
        );
    end

    // Only ever set bits; clearing is left to the CPU side of the register.
    assign o_lgc_wen   = wen;
    assign o_lgc_wdata = wen;

    always_ff @(posedge i_clk) begin
        if (i_rst) o_irq <= 1'b0;
        else       o_irq <= |(i_reg_data & i_irq_en);
    end

endmodule

// File: tb/tb_evt_flt_set.sv
// tb/tb_evt_flt_set.sv - self-checking bench for evt_flt_set
module tb_evt_flt_set;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] evt, evt_en, edge_sel, reg_data, irq_en, wen, wdata;
    logic       irq;
    logic [7:0] evt_b, wen_b, wdata_b;
    logic       irq_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int k;
    bit chk_on = 1'b0;
    logic [7:0] exp_wen;
    logic [7:0] m;

    typedef struct { int cyc; logic [7:0] mask; } exp_t;
    typedef struct { int idx; int len; logic sel; logic en; logic strobe; int delay; } vec_t;
    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    evt_flt_set #(.DW(8), .FLT_CNT_W(4), .FLT_LEN(3), .SYNC_EN(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_evt(evt), .i_evt_en(evt_en), .i_edge_sel(edge_sel),
        .i_reg_data(reg_data), .i_irq_en(irq_en),
        .o_lgc_wen(wen), .o_lgc_wdata(wdata), .o_irq(irq)
    );

    evt_flt_set #(.DW(8), .FLT_CNT_W(4), .FLT_LEN(0), .SYNC_EN(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_evt(evt_b), .i_evt_en(8'hFF), .i_edge_sel(8'h00),
        .i_reg_data(8'h00), .i_irq_en(8'h00),
        .o_lgc_wen(wen_b), .o_lgc_wdata(wdata_b), .o_irq(irq_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every cycle the strobe vector must equal what was queued for it.
    always @(negedge clk) begin
        if (chk_on) begin
            exp_wen = '0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                if (sb[0].cyc < cyc) chk("sb_stale", 32'(sb[0].cyc), 32'(cyc));
                else exp_wen |= sb[0].mask;
                void'(sb.pop_front());
            end
            chk("wen", 32'(wen), 32'(exp_wen));
            chk("wdata", 32'(wdata), 32'(exp_wen));
        end
    end

    initial begin
        // idx, len, sel, en, strobe, delay-from-first-sample
        vecs[0] = '{0, 8, 1'b0, 1'b1, 1'b1, 4};
        vecs[1] = '{3, 2, 1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{3, 3, 1'b0, 1'b1, 1'b1, 4};
        vecs[3] = '{2, 5, 1'b1, 1'b1, 1'b1, 9};
        vecs[4] = '{5, 6, 1'b0, 1'b0, 1'b0, 0};
        vecs[5] = '{4, 1, 1'b0, 1'b1, 1'b0, 0};
        vecs[6] = '{7, 4, 1'b1, 1'b1, 1'b1, 8};
        vecs[7] = '{2, 2, 1'b1, 1'b1, 1'b0, 0};

        rst = 1'b1; evt = '0; evt_en = '1; edge_sel = '0;
        reg_data = '0; irq_en = '0; evt_b = '0;
        step(3);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_wen_b", 32'(wen_b), 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;
        step(3);

        for (int v = 0; v < 8; v++) begin
            edge_sel = '0;
            edge_sel[vecs[v].idx] = vecs[v].sel;
            evt_en = '1;
            evt_en[vecs[v].idx] = vecs[v].en;
            evt[vecs[v].idx] = 1'b1;
            k = cyc + 1;
            m = '0;
            m[vecs[v].idx] = 1'b1;
            if (vecs[v].strobe) sb.push_back('{k + vecs[v].delay, m});
            step(vecs[v].len);
            evt[vecs[v].idx] = 1'b0;
            step(14);
        end
        evt_en = '1; edge_sel = '0;

        // Disabled rise, late enable, edge_sel change: only the later fall strobes.
        evt_en[6] = 1'b0; evt[6] = 1'b1;
        step(8);
        evt_en[6] = 1'b1;
        step(4);
        edge_sel[6] = 1'b1;
        step(2);
        evt[6] = 1'b0;
        k = cyc + 1;
        sb.push_back('{k + 4, 8'h40});
        step(12);
        edge_sel = '0;

        reg_data = 8'h20; irq_en = 8'h20;
        chk("irq_pre", 32'(irq), 32'd0);
        step(1);
        chk("irq_set", 32'(irq), 32'd1);
        step(2);
        chk("irq_hold", 32'(irq), 32'd1);
        irq_en = 8'h00;
        step(1);
        chk("irq_clr", 32'(irq), 32'd0);
        reg_data = 8'h00;

        // Reset mid-count discards the partial count; held input restarts as a new edge.
        evt[1] = 1'b1;
        step(2);
        rst = 1'b1; reg_data = 8'hFF; irq_en = 8'hFF;
        step(1);
        chk("mid_rst_wen", 32'(wen), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        rst = 1'b0; reg_data = 8'h00; irq_en = 8'h00;
        sb.push_back('{cyc + 5, 8'h02});
        step(10);
        evt[1] = 1'b0;
        step(12);

        evt = 8'hFF;
        k = cyc + 1;
        sb.push_back('{k + 4, 8'hFF});
        step(8);
        evt = 8'h00;
        step(12);

        // Zero-length filter, no synchronizer: strobe right after the first sampling edge.
        evt_b = 8'h01;
        chk("b_pre", 32'(wen_b), 32'd0);
        step(1);
        chk("b_rise", 32'(wen_b), 32'h01);
        chk("b_wdata", 32'(wdata_b), 32'h01);
        evt_b = 8'h83;
        step(1);
        chk("b_multi", 32'(wen_b), 32'h82);
        evt_b = 8'h00;
        step(1);
        chk("b_fall", 32'(wen_b), 32'h00);
        chk("b_irq", 32'(irq_b), 32'd0);

        step(5);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
